// File: rtl/weight_stream_sender.sv
// Transmit end of the layer weight-load channel: tags each upstream weight with its neuron index
// and closes the load with a terminator beat. Optional WSEND_CKSUM_EN adds a running cksum output.
module weight_stream_sender #(
  parameter int NEURONS = 20,
  parameter int IDX_W   = 5
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [3:0]  input_dim,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [15:0] s_tdata,
  input  logic        s_tlast,
  output logic [15:0] w_tdata,
  output logic [7:0]  w_tid,
  output logic        busy,
  output logic        done,
`ifdef WSEND_CKSUM_EN
  output logic        err,
  output logic [15:0] cksum
`else
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    TERM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       dim_r;
  logic [IDX_W-1:0] n_r;
  logic [3:0]       k_r;
  logic [15:0]      w_tdata_r;
  logic [7:0]       w_tid_r;
  logic             busy_r, done_r, err_r;
  logic             start_ok_s, accept_s, k_wrap_s, last_s, frame_err_s;

  // Next-state decode plus accept/last-beat/framing qualifiers
  always_comb begin
    state_s     = state_r;
    start_ok_s  = 1'b0;
    accept_s    = 1'b0;
    k_wrap_s    = 1'b0;
    last_s      = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_ok_s = 1'b1;
          state_s    = (input_dim != 4'd0) ? SEND : TERM;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        accept_s = s_tvalid;
        k_wrap_s = (k_r == (dim_r - 4'd1));
        last_s   = k_wrap_s && (n_r == IDX_W'(NEURONS - 1));
        if (accept_s) begin
          frame_err_s = (s_tlast != last_s);
          state_s     = last_s ? TERM : SEND;
        end else begin
          state_s = SEND;
        end
      end
      TERM:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered beat outputs, neuron-major counters and status flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dim_r     <= 4'd0;
      n_r       <= '0;
      k_r       <= 4'd0;
      w_tdata_r <= 16'h0000;
      w_tid_r   <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      w_tid_r <= 8'h00;
      done_r  <= (state_r == DONE);
      busy_r  <= (state_s != IDLE);
      if (start_ok_s) begin
        dim_r <= input_dim;
        err_r <= 1'b0;
        n_r   <= '0;
        k_r   <= 4'd0;
      end
      if (accept_s) begin
        w_tdata_r <= s_tdata;
        w_tid_r   <= {3'b100, n_r};
        if (k_wrap_s) begin
          k_r <= 4'd0;
          n_r <= n_r + IDX_W'(1);
        end else begin
          k_r <= k_r + 4'd1;
        end
        if (frame_err_s) begin
          err_r <= 1'b1;
        end
      end
      if (state_r == TERM) begin
        w_tid_r   <= 8'h40;
        w_tdata_r <= 16'h0000;
      end
    end
  end

`ifdef WSEND_CKSUM_EN
  logic [15:0] cksum_r;

  // Modulo-2^16 running sum of accepted weights for the current load
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cksum_r <= 16'h0000;
    end else if (start_ok_s) begin
      cksum_r <= 16'h0000;
    end else if (accept_s) begin
      cksum_r <= cksum_r + s_tdata;
    end else begin
      cksum_r <= cksum_r;
    end
  end

  assign cksum = cksum_r;
`endif

  assign s_tready = (state_r == SEND);
  assign w_tdata  = w_tdata_r;
  assign w_tid    = w_tid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_weight_stream_sender.sv
// Directed bench for weight_stream_sender: full loads, gapped loads, dim=0, framing errors, mid-load reset.
// Checksum checks are compiled in when WSEND_CKSUM_EN is defined.
module tb_weight_stream_sender;
  localparam int NEURONS = 20;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  input_dim = 4'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] s_tdata = 16'h0000;
  logic        s_tlast = 1'b0;
  logic [15:0] w_tdata;
  logic [7:0]  w_tid;
  logic        busy, done, err;
`ifdef WSEND_CKSUM_EN
  logic [15:0] cksum;
`endif

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  weight_stream_sender #(.NEURONS(NEURONS), .IDX_W(5)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .input_dim(input_dim),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .w_tdata(w_tdata), .w_tid(w_tid), .busy(busy), .done(done),
`ifdef WSEND_CKSUM_EN
    .err(err), .cksum(cksum)
`else
    .err(err)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load: toggle inserts idle gaps, bad misplaces s_tlast (beat 5 set, last beat clear),
  // stop_after>0 returns after that many accepted beats, fixed!=0 sends a constant word.
  task automatic run_load(input logic [3:0] dim, input bit toggle, input bit bad,
                          input int stop_after, input logic [15:0] fixed);
    int          total;
    int          beat;
    int          cyc;
    bit          gap;
    bit          err_exp;
    logic [15:0] word;
    logic [15:0] last_data;
    logic [15:0] sum;
    total     = NEURONS * int'(dim);
    beat      = 0;
    cyc       = 0;
    err_exp   = 1'b0;
    sum       = 16'h0000;
    last_data = w_tdata;
    start     = 1'b1;
    input_dim = dim;
    s_tvalid  = 1'b0;
    @(posedge aclk); #1;
    start = 1'b0;
    chk("busy_after_start", {15'd0, busy}, 16'd1);
    chk("err_cleared", {15'd0, err}, 16'd0);
    chk("ready_after_start", {15'd0, s_tready}, (dim != 4'd0) ? 16'd1 : 16'd0);
    chk("tid_after_start", {8'd0, w_tid}, 16'h0000);
    while (beat < total && cyc < 2000) begin
      gap      = toggle && ((cyc % 2) == 1);
      word     = (fixed != 16'h0000) ? fixed : 16'(beat + 1);
      s_tvalid = !gap;
      s_tdata  = word;
      s_tlast  = bad ? (beat == 4) : (beat == total - 1);
      if (gap && cyc == 3) begin
        start     = 1'b1;
        input_dim = 4'd5;
      end
      @(posedge aclk); #1;
      start = 1'b0;
      if (gap) begin
        chk("gap_tid", {8'd0, w_tid}, 16'h0000);
        chk("gap_hold", w_tdata, last_data);
      end else begin
        if (bad && (beat == 4 || beat == total - 1)) err_exp = 1'b1;
        chk("data_tid", {8'd0, w_tid}, {8'd0, 3'b100, 5'(beat / int'(dim))});
        chk("data_word", w_tdata, word);
        chk("err_track", {15'd0, err}, {15'd0, err_exp});
        last_data = word;
        sum       = sum + word;
        beat++;
        if (beat == stop_after) return;
      end
      cyc++;
    end
    if (beat < total) chk("load_timeout", 16'(beat), 16'(total));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
`ifdef WSEND_CKSUM_EN
    chk("cksum_last", cksum, sum);
`endif
    @(posedge aclk); #1;
    chk("term_tid", {8'd0, w_tid}, 16'h0040);
    chk("term_data", w_tdata, 16'h0000);
    chk("term_done", {15'd0, done}, 16'd0);
    chk("term_busy", {15'd0, busy}, 16'd1);
    chk("term_ready", {15'd0, s_tready}, 16'd0);
    @(posedge aclk); #1;
    chk("done_pulse", {15'd0, done}, 16'd1);
    chk("done_busy", {15'd0, busy}, 16'd0);
    chk("done_tid", {8'd0, w_tid}, 16'h0000);
    chk("done_err", {15'd0, err}, {15'd0, err_exp});
`ifdef WSEND_CKSUM_EN
    chk("cksum_hold", cksum, sum);
`endif
    @(posedge aclk); #1;
    chk("done_single", {15'd0, done}, 16'd0);
  endtask

  initial begin
    #1;
    chk("rst_tid", {8'd0, w_tid}, 16'h0000);
    chk("rst_data", w_tdata, 16'h0000);
    chk("rst_flags", {12'd0, s_tready, busy, done, err}, 16'h0000);
    #21 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Contiguous 60-beat load, dim=3
    run_load(4'd3, 1'b0, 1'b0, -1, 16'h0000);
    // Same load with upstream valid toggling; a start mid-load must be ignored
    run_load(4'd3, 1'b1, 1'b0, -1, 16'h0000);
    // dim=0: straight to terminator
    run_load(4'd0, 1'b0, 1'b0, -1, 16'h0000);
    // dim=2 with misplaced s_tlast, then a clean load clears err
    run_load(4'd2, 1'b0, 1'b1, -1, 16'h0000);
    run_load(4'd1, 1'b0, 1'b0, -1, 16'h0000);

    // Abort after 17 beats
    run_load(4'd3, 1'b0, 1'b0, 17, 16'h0000);
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    #1;
    chk("abort_tid", {8'd0, w_tid}, 16'h0000);
    chk("abort_data", w_tdata, 16'h0000);
    chk("abort_flags", {12'd0, s_tready, busy, done, err}, 16'h0000);
`ifdef WSEND_CKSUM_EN
    chk("abort_cksum", cksum, 16'h0000);
`endif
    @(posedge aclk); #1;
    chk("abort_no_term", {8'd0, w_tid}, 16'h0000);
    #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    run_load(4'd3, 1'b0, 1'b0, -1, 16'h0000);

`ifdef WSEND_CKSUM_EN
    run_load(4'd3, 1'b0, 1'b0, -1, 16'h1000);
    chk("cksum_c000", cksum, 16'hC000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
